fifo_drain: RTL and testbench

- Read-side companion to the team's synchronous FIFO.
- Drives the FIFO read port (rd_en, data_op, empty) and converts it into a valid/ready stream for downstream consumers.
- Absorbs the FIFO's one-cycle read latency with an internal 2-entry output buffer, so downstream backpressure never loses a word and full throughput is sustained when the consumer is always ready.

---
 rtl/fifo_drain.sv | 119 +++++++++++
 tb/tb_fifo_drain.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: read-side companion to the synchronous FIFO.
//
// Issues FIFO reads and turns the FIFO's one-cycle-latency read port into a
// valid/ready stream. A 2-entry output buffer absorbs the read latency. No
// word is lost under downstream backpressure, and one word per cycle is
// sustained when the consumer is always ready.
//
// Optional feature (macro FIFO_DRAIN_CNT_EN): adds output rd_count, a
// wrapping count of words accepted downstream.
//
// Ports:
//   clk      system clock, all state on posedge
//   rst      asynchronous active-high reset
//   en       drain enable; gates new FIFO reads only
//   empty    FIFO empty flag
//   data_op  FIFO read data, valid one cycle after rd_en
//   rd_en    FIFO read strobe (combinational)
//   m_valid  output word valid (registered)
//   m_data   output word, buffer head (registered)
//   m_ready  downstream accept
//   busy     buffer occupied or read in flight
//   rd_count popped-word counter (FIFO_DRAIN_CNT_EN only)

module fifo_drain #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_op,
    output logic              rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
`ifdef FIFO_DRAIN_CNT_EN
    output logic [CNT_W-1:0]  rd_count,
`endif
    output logic              busy
);

    logic [1:0]        occ_q, occ_d;
    logic              infl_q;
    logic              valid_q;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic              pop;
    logic [2:0]        level;
    logic [1:0]        slot;

    assign pop = valid_q & m_ready;

    // Occupancy after this edge, counting the word currently in flight.
    assign level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

    // Only issue a read if the buffer will have room when its data arrives.
    assign rd_en = en & ~empty & ~rst & (level < 3'd2);

    // In-flight data lands in the first free slot after any pop.
    assign slot = occ_q - {1'b0, pop};

    always_comb begin
        occ_d  = level[1:0];
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop && (occ_q == 2'd2)) begin
            buf0_d = buf1_q;
        end
        if (infl_q) begin
            if (slot == 2'd0) begin
                buf0_d = data_op;
            end else begin
                buf1_d = data_op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= 2'd0;
            infl_q  <= 1'b0;
            valid_q <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            infl_q  <= rd_en;
            valid_q <= (occ_d != 2'd0);
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = buf0_q;
    assign busy    = (occ_q != 2'd0) | infl_q;

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rd_count = cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

    // The read gate guarantees the buffer never needs a third slot.
    overflow_chk : assert property (@(posedge clk) disable iff (rst) level <= 3'd2);

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              empty = 1'b1;
    logic [DATA_W-1:0] data_op = '0;
    logic              rd_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready = 1'b0;
    logic              busy;
`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_W-1:0]  rd_count;
`endif

    fifo_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .empty   (empty),
        .data_op (data_op),
        .rd_en   (rd_en),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
`ifdef FIFO_DRAIN_CNT_EN
        .rd_count(rd_count),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic [7:0] fifo_q[$];   // words still inside the modelled FIFO
    exp_t       exp_q[$];    // words read from the FIFO, not yet delivered

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int reads_total = 0;
    int delivered = 0;
    bit rd_seen = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // FIFO model: pops on a read seen in the previous cycle, presents data one cycle later.
    always begin
        logic [7:0] w;
        bit         have;
        @(posedge clk);
        have = 0;
        if (rd_seen) begin
            if (fifo_q.size() == 0) begin
                chk("read_while_empty", 32'd1, 32'd0);
            end else begin
                w = fifo_q.pop_front();
                exp_q.push_back('{data: w, cyc: cyc});
                reads_total++;
                have = 1;
            end
        end
        cyc++;
        #1;
        data_op = have ? w : 8'($urandom);
        #1;
        empty = (fifo_q.size() == 0);
    end

    // Monitor: compares DUT outputs with the scoreboard on the falling edge.
    bit         exp_vld, exp_pop, prev_hold;
    int         lvl;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rd_en", 32'(rd_en), 32'd0);
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_m_data", 32'(m_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            rd_seen   = 0;
            prev_hold = 0;
            delivered = 0;
        end else begin
            exp_vld = 0;
            if (exp_q.size() != 0) exp_vld = (exp_q[0].cyc + 2 <= cyc);
            exp_pop = exp_vld && m_ready;
            lvl = exp_q.size() - (exp_pop ? 1 : 0);
            chk("rd_en", 32'(rd_en), 32'(en && !empty && (lvl < 2)));
            chk("m_valid", 32'(m_valid), 32'(exp_vld));
            if (exp_vld) chk("m_data", 32'(m_data), 32'(exp_q[0].data));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (prev_hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
`ifdef FIFO_DRAIN_CNT_EN
            chk("rd_count", 32'(rd_count), 32'(delivered % (1 << CNT_W)));
`endif
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (exp_pop) begin
                void'(exp_q.pop_front());
                delivered++;
            end
            rd_seen = rd_en;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_read(input string name);
        int r0 = reads_total;
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step(1);
            ok = (reads_total != r0);
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic drain(input string name);
        bit done = 0;
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            step(1);
            done = (fifo_q.size() == 0) && (exp_q.size() == 0) && !busy;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic preload(input logic [7:0] first, input int n, input logic [7:0] inc);
        logic [7:0] v = first;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(v);
            v = v + inc;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0;
        bit seen;

        // Reset with an empty FIFO; en high shows empty gating.
        rst = 1'b1;
        en = 1'b1;
        m_ready = 1'b1;
        #156;
        rst = 1'b0;
        step(4);

        // Streaming at full rate.
        r0 = reads_total;
        preload(8'h11, 4, 8'h11);
        drain("stream_drain");
        chk("stream_reads", 32'(reads_total - r0), 32'd4);
        chk("stream_delivered", 32'(delivered), 32'd4);

        // Backpressure: buffer fills to two and holds the head.
        en = 1'b0;
        m_ready = 1'b0;
        r0 = reads_total;
        preload(8'h11, 4, 8'h11);
        step(1);
        en = 1'b1;
        step(10);
        chk("bp_reads", 32'(reads_total - r0), 32'd2);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data", 32'(m_data), 32'h11);
        chk("bp_rd_en", 32'(rd_en), 32'd0);
        d0 = delivered;
        drain("bp_drain");
        chk("bp_delivered", 32'(delivered - d0), 32'd4);

        // Alternating ready with 8 words.
        d0 = delivered;
        preload(8'h01, 8, 8'h01);
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            step(1);
        end
        drain("alt_drain");
        chk("alt_delivered", 32'(delivered - d0), 32'd8);

        // en dropped the cycle after the first read.
        en = 1'b0;
        preload(8'h11, 2, 8'h11);
        d0 = delivered;
        step(1);
        en = 1'b1;
        wait_read("en_first_read");
        en = 1'b0;
        r0 = reads_total;
        step(6);
        chk("en_off_no_read", 32'(reads_total - r0), 32'd0);
        chk("en_off_delivered", 32'(delivered - d0), 32'd1);
        drain("en_drain");
        chk("en_on_delivered", 32'(delivered - d0), 32'd2);

        // Reset while one word is buffered and one in flight.
        en = 1'b0;
        m_ready = 1'b0;
        preload(8'hA1, 6, 8'h01);
        step(1);
        en = 1'b1;
        wait_read("mrst_first_read");
        step(1);
        chk("mrst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mrst_m_valid", 32'(m_valid), 32'd0);
        chk("mrst_m_data", 32'(m_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rd_en", 32'(rd_en), 32'd0);
        step(2);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            seen = m_valid;
        end
        chk("mrst_valid_seen", 32'(seen), 32'd1);
        chk("mrst_next_word", 32'(m_data), 32'hA3);
        drain("mrst_drain");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if (fifo_q.size() < 5 && $urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
            step(1);
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
